// File: rtl/ct_f_spsram_arb_pkg.sv
// Shared types and helpers for the single-port SRAM arbiter/sequencer.
// State encoding, requester count and array depth derivation.
package ct_f_spsram_arb_pkg;

  localparam int REQ_NUM = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int calc_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/ct_f_spsram_rr_arb.sv
// Two-way round-robin arbiter, combinational one-hot grant, pointer flop updated on grant.
// Pointer resets to favour requester 0.
module ct_f_spsram_rr_arb
  import ct_f_spsram_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [REQ_NUM-1:0] vld,
  output logic [REQ_NUM-1:0] gnt
);

  // ptr=0 favours requester 0, ptr=1 favours requester 1
  logic ptr_q;

  always_comb begin
    gnt = '0;
    if (enable) begin
      if (&vld) begin
        gnt = ptr_q ? 2'b10 : 2'b01;
      end else begin
        gnt = vld;
      end
    end
  end

  // After a grant, favour the requester that did not win
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (|gnt) begin
      ptr_q <= gnt[0];
    end
  end

endmodule

// File: rtl/ct_f_spsram_arb_ctrl.sv
// Two-requester arbiter/sequencer for a single-port SRAM wrapper; reads return on T+1.
// CT_SPSRAM_ARB_INIT_EN: zero-fill the whole array after reset before granting traffic.
module ct_f_spsram_arb_ctrl
  import ct_f_spsram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 144
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,

  input  logic                  req0_vld,
  input  logic                  req0_wr,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [DATA_WIDTH-1:0] req0_wmask,
  output logic                  req0_rdy,
  output logic                  rsp0_vld,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,

  input  logic                  req1_vld,
  input  logic                  req1_wr,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic [DATA_WIDTH-1:0] req1_wmask,
  output logic                  req1_rdy,
  output logic                  rsp1_vld,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,

  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic                  ram_cen,
  output logic [DATA_WIDTH-1:0] ram_d,
  output logic                  ram_gwen,
  output logic [DATA_WIDTH-1:0] ram_wen,
  input  logic [DATA_WIDTH-1:0] ram_q,

  output logic                  init_done
);

  state_t               state_q;
  state_t               state_nxt;
  logic [REQ_NUM-1:0]   gnt;
  logic [REQ_NUM-1:0]   rsp_own_q;
  logic                 run_en;

  // Qualifying with cpurst_b keeps every RAM strobe and ready inactive while reset is held
  assign run_en = (state_q == ST_RUN) & cpurst_b;

`ifdef CT_SPSRAM_ARB_INIT_EN
  localparam int DEPTH = calc_depth(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] init_cnt_q;
  logic                  init_wr;

  assign init_wr = (state_q == ST_INIT) & cpurst_b;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      init_cnt_q <= '0;
    end else if (state_q == ST_INIT) begin
      init_cnt_q <= init_cnt_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
`ifdef CT_SPSRAM_ARB_INIT_EN
      state_q <= ST_INIT;
`else
      state_q <= ST_RUN;
`endif
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
`ifdef CT_SPSRAM_ARB_INIT_EN
    if (state_q == ST_INIT && init_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
      state_nxt = ST_RUN;
    end
`endif
  end

  ct_f_spsram_rr_arb u_rr_arb (
    .clk    (forever_cpuclk),
    .rst_n  (cpurst_b),
    .enable (run_en),
    .vld    ({req1_vld, req0_vld}),
    .gnt    (gnt)
  );

  always_comb begin
    ram_cen  = 1'b1;
    ram_gwen = 1'b1;
    ram_wen  = '1;
    ram_a    = '0;
    ram_d    = '0;
`ifdef CT_SPSRAM_ARB_INIT_EN
    if (init_wr) begin
      ram_cen  = 1'b0;
      ram_gwen = 1'b0;
      ram_wen  = '0;
      ram_a    = init_cnt_q;
    end else
`endif
    if (gnt[1]) begin
      ram_cen  = 1'b0;
      ram_a    = req1_addr;
      ram_d    = req1_wdata;
      ram_gwen = ~req1_wr;
      ram_wen  = req1_wr ? ~req1_wmask : '1;
    end else if (gnt[0]) begin
      ram_cen  = 1'b0;
      ram_a    = req0_addr;
      ram_d    = req0_wdata;
      ram_gwen = ~req0_wr;
      ram_wen  = req0_wr ? ~req0_wmask : '1;
    end
  end

  // Only reads produce a response; the owner is remembered for the T+1 sample of Q
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rsp_own_q <= '0;
    end else begin
      rsp_own_q <= {gnt[1] & ~req1_wr, gnt[0] & ~req0_wr};
    end
  end

  assign req0_rdy   = gnt[0];
  assign req1_rdy   = gnt[1];
  assign rsp0_vld   = rsp_own_q[0];
  assign rsp1_vld   = rsp_own_q[1];
  assign rsp0_rdata = rsp_own_q[0] ? ram_q : '0;
  assign rsp1_rdata = rsp_own_q[1] ? ram_q : '0;
  assign init_done  = (state_q == ST_RUN);

endmodule

// File: tb/tb_ct_f_spsram_arb_ctrl.sv
// Bench for ct_f_spsram_arb_ctrl with a behavioural single-port RAM and a reference model.
module tb_ct_f_spsram_arb_ctrl;

  localparam int AW    = 10;
  localparam int DW    = 144;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          req0_vld, req0_wr, req1_vld, req1_wr;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req0_wmask, req1_wdata, req1_wmask;
  logic          req0_rdy, req1_rdy, rsp0_vld, rsp1_vld;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic [AW-1:0] ram_a;
  logic          ram_cen, ram_gwen;
  logic [DW-1:0] ram_d, ram_wen, ram_q;
  logic          init_done;

  always #5 clk = ~clk;

  ct_f_spsram_arb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_b),
    .req0_vld       (req0_vld),
    .req0_wr        (req0_wr),
    .req0_addr      (req0_addr),
    .req0_wdata     (req0_wdata),
    .req0_wmask     (req0_wmask),
    .req0_rdy       (req0_rdy),
    .rsp0_vld       (rsp0_vld),
    .rsp0_rdata     (rsp0_rdata),
    .req1_vld       (req1_vld),
    .req1_wr        (req1_wr),
    .req1_addr      (req1_addr),
    .req1_wdata     (req1_wdata),
    .req1_wmask     (req1_wmask),
    .req1_rdy       (req1_rdy),
    .rsp1_vld       (rsp1_vld),
    .rsp1_rdata     (rsp1_rdata),
    .ram_a          (ram_a),
    .ram_cen        (ram_cen),
    .ram_d          (ram_d),
    .ram_gwen       (ram_gwen),
    .ram_wen        (ram_wen),
    .ram_q          (ram_q),
    .init_done      (init_done)
  );

  // Behavioural single-port RAM wrapper; the fill port preloads junk while the DUT is in reset
  logic [DW-1:0] mem [DEPTH];
  logic          fill_en;
  logic [AW-1:0] fill_addr;
  logic [DW-1:0] fill_dat;

  always @(posedge clk) begin
    if (fill_en) begin
      mem[fill_addr] <= fill_dat;
    end else if (!ram_cen) begin
      if (!ram_gwen) mem[ram_a] <= (mem[ram_a] & ram_wen) | (ram_d & ~ram_wen);
      else           ram_q <= mem[ram_a];
    end
  end

  // Reference model
  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  int            last_gnt;
  logic          exp_vld [2];
  logic [DW-1:0] exp_dat [2];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_w();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic model_reset();
    last_gnt = 1;
    exp_vld[0] = 1'b0;
    exp_vld[1] = 1'b0;
  endtask

  task automatic set_req(input int n, input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] m);
    if (n == 0) begin
      req0_vld = v; req0_wr = w; req0_addr = a; req0_wdata = d; req0_wmask = m;
    end else begin
      req1_vld = v; req1_wr = w; req1_addr = a; req1_wdata = d; req1_wmask = m;
    end
  endtask

  task automatic idle_reqs();
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // One clock: check DUT against the model at negedge, then advance the model
  task automatic step();
    int            g;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d, m;
    @(negedge clk);
    if (req0_vld && req1_vld) g = (last_gnt == 0) ? 1 : 0;
    else if (req0_vld)        g = 0;
    else if (req1_vld)        g = 1;
    else                      g = -1;
    chk1("rdy0", req0_rdy, g == 0);
    chk1("rdy1", req1_rdy, g == 1);
    chk1("rsp0_vld", rsp0_vld, exp_vld[0]);
    chk1("rsp1_vld", rsp1_vld, exp_vld[1]);
    if (exp_vld[0]) chkw("rsp0_rdata", rsp0_rdata, exp_dat[0]);
    if (exp_vld[1]) chkw("rsp1_rdata", rsp1_rdata, exp_dat[1]);
    chk1("ram_cen", ram_cen, g < 0);
    exp_vld[0] = 1'b0;
    exp_vld[1] = 1'b0;
    if (g >= 0) begin
      w = (g == 0) ? req0_wr    : req1_wr;
      a = (g == 0) ? req0_addr  : req1_addr;
      d = (g == 0) ? req0_wdata : req1_wdata;
      m = (g == 0) ? req0_wmask : req1_wmask;
      chkw("ram_a", DW'(ram_a), DW'(a));
      chk1("ram_gwen", ram_gwen, ~w);
      chkw("ram_wen", ram_wen, w ? ~m : '1);
      if (w) begin
        chkw("ram_d", ram_d, d);
        ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
      end else begin
        exp_vld[g] = 1'b1;
        exp_dat[g] = ref_mem[a];
      end
      last_gnt = g;
    end
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] ones;
  logic [DW-1:0] a5;
  logic [DW-1:0] junk;

  initial begin
    ones = '1;
    a5   = {18{8'hA5}};
    rst_b = 1'b0;
    fill_en = 1'b0;
    fill_addr = '0;
    fill_dat = '0;
    idle_reqs();
    model_reset();
    req0_vld = 1'b1;
    req1_vld = 1'b1;

    // Preload junk so that unwritten or un-zeroed locations are visible
    for (int i = 0; i < DEPTH; i++) begin
      junk = rand_w();
      fill_en = 1'b1;
      fill_addr = AW'(i);
      fill_dat = junk;
      ref_mem[i] = junk;
      @(posedge clk);
      #1;
    end
    fill_en = 1'b0;

    @(negedge clk);
    chk1("rst_rdy0", req0_rdy, 1'b0);
    chk1("rst_rdy1", req1_rdy, 1'b0);
    chk1("rst_rsp0_vld", rsp0_vld, 1'b0);
    chk1("rst_rsp1_vld", rsp1_vld, 1'b0);
    chk1("rst_cen", ram_cen, 1'b1);
    chk1("rst_gwen", ram_gwen, 1'b1);
    chkw("rst_wen", ram_wen, ones);
    chkw("rst_a", DW'(ram_a), '0);
    chkw("rst_d", ram_d, '0);
`ifdef CT_SPSRAM_ARB_INIT_EN
    chk1("rst_init_done", init_done, 1'b0);
`else
    chk1("rst_init_done", init_done, 1'b1);
`endif
    @(posedge clk);
    #1;

`ifdef CT_SPSRAM_ARB_INIT_EN
    begin
      logic bad;
      int   k;
      // Partial init with both requesters asserting; reset at counter 300
      rst_b = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (ram_a !== AW'(i) || ram_cen !== 1'b0 || ram_gwen !== 1'b0 || ram_wen !== '0 ||
            ram_d !== '0 || req0_rdy !== 1'b0 || req1_rdy !== 1'b0 || init_done !== 1'b0)
          bad = 1'b1;
        @(posedge clk);
        #1;
      end
      chk1("init_partial_ok", bad, 1'b0);
      @(negedge clk);
      chkw("init_a_at_300", DW'(ram_a), DW'(300));
      rst_b = 1'b0;
      #1;
      chk1("midinit_rst_cen", ram_cen, 1'b1);
      chk1("midinit_rst_rdy0", req0_rdy, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_b = 1'b1;
      model_reset();

      // Full init from address 0; bounded wait for init_done
      bad = 1'b0;
      k = 0;
      while (k < 2000) begin
        @(negedge clk);
        if (ram_a !== AW'(k) || ram_cen !== 1'b0 || req0_rdy !== 1'b0 || req1_rdy !== 1'b0)
          bad = 1'b1;
        @(posedge clk);
        #1;
        k++;
        if (init_done === 1'b1) break;
      end
      chk1("init_full_ok", bad, 1'b0);
      chkw("init_cycles", DW'(k), DW'(DEPTH));
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      idle_reqs();
      set_req(0, 1'b1, 1'b0, AW'(0), '0, '0);    step();
      set_req(0, 1'b1, 1'b0, AW'(512), '0, '0);  step();
      set_req(0, 1'b1, 1'b0, AW'(1023), '0, '0); step();
      idle_reqs();
      chkw("init_rd1023_zero", rsp0_rdata, '0);
      step();
    end
`else
    idle_reqs();
    rst_b = 1'b1;
    set_req(0, 1'b1, 1'b0, AW'(7), '0, '0);
    chk1("noinit_done", init_done, 1'b1);
    step();
    idle_reqs();
    step();
`endif

    // Masked write: all ones, then zeros on bits [7:0] only, then read back
    set_req(0, 1'b1, 1'b1, AW'(5), ones, ones);                  step();
    set_req(0, 1'b1, 1'b1, AW'(5), '0, {{(DW-8){1'b0}}, 8'hFF}); step();
    set_req(0, 1'b1, 1'b0, AW'(5), '0, '0);                      step();
    idle_reqs();
    chkw("masked_rd", rsp0_rdata, {{(DW-8){1'b1}}, 8'h00});
    step();

    // Back-to-back write then read of the same address from req1
    set_req(1, 1'b1, 1'b1, AW'(10'h3FF), a5, ones); step();
    set_req(1, 1'b1, 1'b0, AW'(10'h3FF), '0, '0);   step();
    idle_reqs();
    chk1("b2b_rsp1_vld", rsp1_vld, 1'b1);
    chkw("b2b_rsp1_rdata", rsp1_rdata, a5);
    step();

    // Contention: both requesters read continuously
    for (int i = 0; i < 24; i++) begin
      set_req(0, 1'b1, 1'b0, AW'($urandom_range(0, 15)), '0, '0);
      set_req(1, 1'b1, 1'b0, AW'($urandom_range(0, 15)), '0, '0);
      step();
    end

    // Random mixed traffic over a small address window
    for (int i = 0; i < 300; i++) begin
      for (int n = 0; n < 2; n++) begin
        set_req(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                AW'($urandom_range(0, 15)), rand_w(), rand_w());
      end
      step();
    end
    idle_reqs();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
